// File: rtl/cu_multicycle_if.sv
// rtl/cu_multicycle_if.sv - IR fields, memory handshakes and datapath controls of the multicycle control unit
interface cu_multicycle_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             IrWr;
  logic             PCWr;
  logic             RUWr;
  logic             DmWr;
  logic [2:0]       ImmSrc;
  logic             AluAsrc;
  logic             AluBsrc;
  logic [3:0]       AluOp;
  logic [4:0]       BrOp;
  logic [2:0]       DmCtrl;
  logic [1:0]       RUDataWrSrc;
  logic [2:0]       state;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, funct3, funct7, imem_ack, dmem_ack,
    output imem_req, dmem_req, IrWr, PCWr, RUWr, DmWr, ImmSrc, AluAsrc, AluBsrc,
           AluOp, BrOp, DmCtrl, RUDataWrSrc, state, trap, trap_cause, instret
  );

  modport slave (
    output opcode, funct3, funct7, imem_ack, dmem_ack,
    input  imem_req, dmem_req, IrWr, PCWr, RUWr, DmWr, ImmSrc, AluAsrc, AluBsrc,
           AluOp, BrOp, DmCtrl, RUDataWrSrc, state, trap, trap_cause, instret
  );
endinterface

// File: rtl/cu_multicycle.sv
// rtl/cu_multicycle.sv - multicycle RV32I control FSM with memory watchdog, trapping and instret
module cu_multicycle #(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32,
  parameter bit          SYS_TRAP = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  cu_multicycle_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b111
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_NOP
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           state_q;
  cls_e             cls_q;
  logic [WD_W-1:0]  wd_q;
  logic             trap_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] instret_q;
  logic [2:0]       imm_q;
  logic             asrc_q;
  logic             bsrc_q;
  logic [3:0]       aluop_q;
  logic [4:0]       brop_q;
  logic [2:0]       dmctrl_q;
  logic [1:0]       wrsrc_q;

  cls_e       cls_d;
  logic [2:0] imm_d;
  logic       asrc_d;
  logic       bsrc_d;
  logic [3:0] aluop_d;
  logic [4:0] brop_d;
  logic [2:0] dmctrl_d;
  logic [1:0] wrsrc_d;
  logic       illegal;
  logic       is_sys;
  logic       wd_expire;
  logic       pc_wr;
  logic       ru_wr;

  // Next-instruction decode; only sampled in DECODE while IR is stable.
  always_comb begin
    cls_d    = C_ALU;
    imm_d    = 3'b000;
    asrc_d   = 1'b0;
    bsrc_d   = 1'b0;
    aluop_d  = 4'b0000;
    brop_d   = 5'b00000;
    dmctrl_d = 3'b000;
    wrsrc_d  = 2'b00;
    illegal  = 1'b0;
    is_sys   = 1'b0;
    case (bus.opcode)
      OP_R: begin
        aluop_d = {bus.funct7[5], bus.funct3};
        if (bus.funct7 == 7'b0100000)
          illegal = !(bus.funct3 == 3'b000 || bus.funct3 == 3'b101);
        else
          illegal = (bus.funct7 != 7'b0000000);
      end
      OP_IMM: begin
        bsrc_d  = 1'b1;
        aluop_d = {1'b0, bus.funct3};
        if (bus.funct3 == 3'b001) begin
          illegal = (bus.funct7 != 7'b0000000);
        end else if (bus.funct3 == 3'b101) begin
          aluop_d = {bus.funct7[5], bus.funct3};
          illegal = !(bus.funct7 == 7'b0000000 || bus.funct7 == 7'b0100000);
        end
      end
      OP_LOAD: begin
        cls_d    = C_LOAD;
        bsrc_d   = 1'b1;
        dmctrl_d = bus.funct3;
        wrsrc_d  = 2'b01;
        illegal  = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
      end
      OP_STORE: begin
        cls_d    = C_STORE;
        imm_d    = 3'b001;
        bsrc_d   = 1'b1;
        dmctrl_d = bus.funct3;
        illegal  = (bus.funct3 > 3'b010);
      end
      OP_BRANCH: begin
        cls_d   = C_BRANCH;
        imm_d   = 3'b010;
        aluop_d = 4'b1000;
        brop_d  = {2'b01, bus.funct3};
        illegal = (bus.funct3 == 3'b010) || (bus.funct3 == 3'b011);
      end
      OP_JAL: begin
        cls_d   = C_JUMP;
        imm_d   = 3'b100;
        asrc_d  = 1'b1;
        bsrc_d  = 1'b1;
        brop_d  = 5'b10000;
        wrsrc_d = 2'b10;
      end
      OP_JALR: begin
        cls_d   = C_JUMP;
        bsrc_d  = 1'b1;
        brop_d  = 5'b10000;
        wrsrc_d = 2'b10;
        illegal = (bus.funct3 != 3'b000);
      end
      OP_LUI: begin
        imm_d  = 3'b011;
        bsrc_d = 1'b1;
      end
      OP_AUIPC: begin
        imm_d  = 3'b011;
        asrc_d = 1'b1;
        bsrc_d = 1'b1;
      end
      OP_FENCE:  cls_d = C_NOP;
      OP_SYSTEM: begin
        cls_d  = C_NOP;
        is_sys = SYS_TRAP;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_comb begin
    pc_wr = 1'b0;
    ru_wr = 1'b0;
    case (state_q)
      S_EXEC: begin
        pc_wr = (cls_q == C_BRANCH) || (cls_q == C_JUMP);
        ru_wr = (cls_q == C_JUMP);
      end
      S_MEM: pc_wr = (cls_q == C_STORE) && bus.dmem_ack;
      S_WB: begin
        pc_wr = 1'b1;
        ru_wr = (cls_q != C_NOP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ALU;
      wd_q      <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
      instret_q <= '0;
      imm_q     <= 3'b000;
      asrc_q    <= 1'b0;
      bsrc_q    <= 1'b0;
      aluop_q   <= 4'b0000;
      brop_q    <= 5'b00000;
      dmctrl_q  <= 3'b000;
      wrsrc_q   <= 2'b00;
    end else begin
      if (pc_wr)
        instret_q <= instret_q + 1'b1;
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ack) begin
            state_q <= S_DECODE;
            wd_q    <= '0;
          end else if (wd_expire) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'b10;
            wd_q    <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_DECODE: begin
          cls_q    <= cls_d;
          imm_q    <= imm_d;
          asrc_q   <= asrc_d;
          bsrc_q   <= bsrc_d;
          aluop_q  <= aluop_d;
          brop_q   <= brop_d;
          dmctrl_q <= dmctrl_d;
          wrsrc_q  <= wrsrc_d;
          if (illegal) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'b01;
          end else if (is_sys) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'b11;
          end else if (cls_d == C_NOP) begin
            state_q <= S_WB;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_LOAD, C_STORE:  state_q <= S_MEM;
            C_BRANCH, C_JUMP: state_q <= S_FETCH;
            default:          state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            state_q <= (cls_q == C_STORE) ? S_FETCH : S_WB;
            wd_q    <= '0;
          end else if (wd_expire) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= 2'b10;
            wd_q    <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_TRAP;
      endcase
    end
  end

  // Strobes are forced low while reset is held so nothing fires before the first FETCH.
  assign bus.imem_req    = rst_n && (state_q == S_FETCH);
  assign bus.IrWr        = rst_n && (state_q == S_FETCH) && bus.imem_ack;
  assign bus.dmem_req    = rst_n && (state_q == S_MEM);
  assign bus.DmWr        = rst_n && (state_q == S_MEM) && (cls_q == C_STORE);
  assign bus.PCWr        = rst_n && pc_wr;
  assign bus.RUWr        = rst_n && ru_wr;
  assign bus.ImmSrc      = imm_q;
  assign bus.AluAsrc     = asrc_q;
  assign bus.AluBsrc     = bsrc_q;
  assign bus.AluOp       = aluop_q;
  assign bus.BrOp        = brop_q;
  assign bus.DmCtrl      = dmctrl_q;
  assign bus.RUDataWrSrc = wrsrc_q;
  assign bus.state       = state_q;
  assign bus.trap        = trap_q;
  assign bus.trap_cause  = cause_q;
  assign bus.instret     = instret_q;
endmodule

// File: tb/tb_cu_multicycle.sv
// tb/tb_cu_multicycle.sv - directed self-checking bench for cu_multicycle
module tb_cu_multicycle;
  logic clk;
  logic rst_n;

  cu_multicycle_if #(.CNT_W(32)) bus ();

  cu_multicycle #(.TIMEOUT(4), .CNT_W(32), .SYS_TRAP(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc, n_dreq, n_dmwr, n_ruwr, n_pcwr, dmwr_bad;
  logic [2:0] ruwr_st, pcwr_st, mem_ctrl;
  logic [1:0] ruwr_src;
  logic [4:0] pc_brop;
  logic [3:0] pc_aluop, exec_aluop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_ir(input logic [31:0] w);
    bus.opcode = w[6:0];
    bus.funct3 = w[14:12];
    bus.funct7 = w[31:25];
  endtask

  // Runs one instruction; iwait/dwait are the request cycles before ack (99 = never).
  task automatic run_instr(input logic [31:0] w, input int iwait, input int dwait);
    int fc, mc;
    bit done;
    fc = 0; mc = 0; done = 1'b0;
    cyc = 0; n_dreq = 0; n_dmwr = 0; n_ruwr = 0; n_pcwr = 0; dmwr_bad = 0;
    ruwr_st = 3'b0; pcwr_st = 3'b0; mem_ctrl = 3'b0; ruwr_src = 2'b0;
    pc_brop = 5'b0; pc_aluop = 4'b0; exec_aluop = 4'b0;
    set_ir(w);
    while (!done && cyc < 40) begin
      bus.imem_ack = (bus.state == 3'b000) && (fc == iwait);
      bus.dmem_ack = (bus.state == 3'b011) && (mc == dwait);
      #1;
      cyc++;
      if (bus.state == 3'b000) fc++;
      if (bus.state == 3'b011) begin
        mc++;
        n_dreq += int'(bus.dmem_req);
        mem_ctrl = bus.DmCtrl;
      end
      if (bus.DmWr && !bus.dmem_req) dmwr_bad++;
      n_dmwr += int'(bus.DmWr);
      if (bus.state == 3'b010) exec_aluop = bus.AluOp;
      if (bus.RUWr) begin
        n_ruwr++;
        ruwr_st = bus.state;
        ruwr_src = bus.RUDataWrSrc;
      end
      if (bus.PCWr) begin
        n_pcwr++;
        pcwr_st = bus.state;
        pc_brop = bus.BrOp;
        pc_aluop = bus.AluOp;
        done = 1'b1;
      end
      if (bus.state == 3'b111) done = 1'b1;
      @(posedge clk);
      #2;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    if (!done) chk("instr_budget", 32'(cyc), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    set_ir(32'h0000_0013);
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_trap", 32'(bus.trap), 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_aluop", 32'(bus.AluOp), 32'd0);
    do_reset();

    // add: cycle-by-cycle walk
    set_ir(32'h0020_81B3);
    bus.imem_ack = 1'b1;
    #1;
    chk("add_fetch_state", 32'(bus.state), 32'd0);
    chk("add_irwr", 32'(bus.IrWr), 32'd1);
    chk("add_fetch_ruwr", 32'(bus.RUWr), 32'd0);
    @(posedge clk); #2;
    bus.imem_ack = 1'b0;
    #1;
    chk("add_decode_state", 32'(bus.state), 32'd1);
    chk("add_decode_irwr", 32'(bus.IrWr), 32'd0);
    @(posedge clk); #3;
    chk("add_exec_state", 32'(bus.state), 32'd2);
    chk("add_exec_aluop", 32'(bus.AluOp), 32'd0);
    chk("add_exec_ruwr", 32'(bus.RUWr), 32'd0);
    @(posedge clk); #3;
    chk("add_wb_state", 32'(bus.state), 32'd4);
    chk("add_wb_ruwr", 32'(bus.RUWr), 32'd1);
    chk("add_wb_pcwr", 32'(bus.PCWr), 32'd1);
    chk("add_wb_src", 32'(bus.RUDataWrSrc), 32'd0);
    chk("add_wb_instret", bus.instret, 32'd0);
    @(posedge clk); #2;
    chk("add_instret", bus.instret, 32'd1);
    chk("add_back_fetch", 32'(bus.state), 32'd0);

    run_instr(32'h0000_A283, 0, 2);
    chk("lw_cycles", 32'(cyc), 32'd7);
    chk("lw_dreq", 32'(n_dreq), 32'd3);
    chk("lw_dmctrl", 32'(mem_ctrl), 32'd2);
    chk("lw_ruwr_state", 32'(ruwr_st), 32'd4);
    chk("lw_src", 32'(ruwr_src), 32'd1);
    chk("lw_instret", bus.instret, 32'd2);

    run_instr(32'h0050_A223, 0, 0);
    chk("sw_cycles", 32'(cyc), 32'd4);
    chk("sw_dmwr", 32'(n_dmwr), 32'd1);
    chk("sw_dmwr_noreq", 32'(dmwr_bad), 32'd0);
    chk("sw_ruwr", 32'(n_ruwr), 32'd0);
    chk("sw_pcwr_state", 32'(pcwr_st), 32'd3);
    chk("sw_instret", bus.instret, 32'd3);

    run_instr(32'h0020_9463, 0, 0);
    chk("bne_cycles", 32'(cyc), 32'd3);
    chk("bne_brop", 32'(pc_brop), 32'b01001);
    chk("bne_aluop", 32'(pc_aluop), 32'b1000);
    chk("bne_pcwr_state", 32'(pcwr_st), 32'd2);
    chk("bne_ruwr", 32'(n_ruwr), 32'd0);
    chk("bne_instret", bus.instret, 32'd4);

    run_instr(32'h0080_00EF, 0, 0);
    chk("jal_cycles", 32'(cyc), 32'd3);
    chk("jal_ruwr_state", 32'(ruwr_st), 32'd2);
    chk("jal_src", 32'(ruwr_src), 32'd2);
    chk("jal_brop", 32'(pc_brop), 32'b10000);
    chk("jal_instret", bus.instret, 32'd5);

    run_instr(32'h0010_0093, 3, 0);
    chk("late_ack_cycles", 32'(cyc), 32'd7);
    chk("late_ack_trap", 32'(bus.trap), 32'd0);
    chk("late_ack_aluop", 32'(exec_aluop), 32'd0);
    chk("late_ack_instret", bus.instret, 32'd6);

    run_instr(32'h0000_000F, 0, 0);
    chk("fence_ruwr", 32'(n_ruwr), 32'd0);
    chk("fence_pcwr_state", 32'(pcwr_st), 32'd4);
    chk("fence_instret", bus.instret, 32'd7);

    // reset while waiting in MEM
    set_ir(32'h0000_A283);
    bus.imem_ack = 1'b1;
    @(posedge clk); #2;
    bus.imem_ack = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("mid_mem_state", 32'(bus.state), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(bus.state), 32'd0);
    chk("mid_rst_dreq", 32'(bus.dmem_req), 32'd0);
    chk("mid_rst_ireq", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_pcwr", 32'(bus.PCWr), 32'd0);
    chk("mid_rst_dmctrl", 32'(bus.DmCtrl), 32'd0);
    chk("mid_rst_src", 32'(bus.RUDataWrSrc), 32'd0);
    chk("mid_rst_instret", bus.instret, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_state", 32'(bus.state), 32'd0);
    chk("mid_rel_ireq", 32'(bus.imem_req), 32'd1);

    run_instr(32'h0020_81B3, 99, 0);
    chk("to_cycles", 32'(cyc), 32'd5);
    chk("to_state", 32'(bus.state), 32'd7);
    chk("to_trap", 32'(bus.trap), 32'd1);
    chk("to_cause", 32'(bus.trap_cause), 32'd2);
    bus.imem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("to_sticky_state", 32'(bus.state), 32'd7);
    chk("to_sticky_ireq", 32'(bus.imem_req), 32'd0);
    chk("to_sticky_irwr", 32'(bus.IrWr), 32'd0);
    chk("to_instret", bus.instret, 32'd0);

    do_reset();
    run_instr(32'h0000_007F, 0, 0);
    chk("ill_op_state", 32'(bus.state), 32'd7);
    chk("ill_op_cause", 32'(bus.trap_cause), 32'd1);
    chk("ill_op_wr", 32'(n_ruwr + n_pcwr), 32'd0);

    do_reset();
    run_instr(32'h4020_F1B3, 0, 0);
    chk("ill_f7_state", 32'(bus.state), 32'd7);
    chk("ill_f7_cause", 32'(bus.trap_cause), 32'd1);
    chk("ill_f7_wr", 32'(n_ruwr + n_pcwr), 32'd0);

    do_reset();
    run_instr(32'h0000_0073, 0, 0);
    chk("sys_cause", 32'(bus.trap_cause), 32'd3);
    chk("sys_instret", bus.instret, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
